// File: rtl/ysyx_25020042_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_25020042_ifu
//   Instruction fetch unit sitting directly in front of a combinational
//   instruction ROM. Owns the PC, presents it as the ROM address, and captures
//   {pc, rom_data} into a 2-entry prefetch FIFO whose head is offered to decode
//   over a valid/ready handshake. Fetch stops after an ebreak is fetched, and
//   the block reports halted once that ebreak has been handed to decode.
//
// Ports
//   clk            : clock, rising-edge
//   rst_n          : asynchronous active-low reset
//   rom_addr       : fetch address (the PC register itself, glitch-free)
//   rom_data       : ROM word for rom_addr, same cycle
//   out_valid      : FIFO head valid (suppressed while redirect_valid)
//   out_ready      : decode accepts the head
//   out_inst       : instruction at the FIFO head (0 when empty)
//   out_pc         : PC of the FIFO head (0 when empty)
//   redirect_valid : flush FIFO and restart fetch at redirect_pc
//   redirect_pc    : new fetch target, low two bits ignored
//   halted         : ebreak delivered to decode, fetch stopped
// ---------------------------------------------------------------------------
module ysyx_25020042_ifu #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(32'h8000_0000),
    parameter logic [31:0]           EBREAK_INST = 32'h0010_0073
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halted
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,  // fetching
        S_DRAIN = 2'd1,  // ebreak fetched, emptying FIFO
        S_HALT  = 2'd2   // ebreak delivered
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_halted;

    // Two-entry FIFO storage; 1-bit pointers wrap 1->0 by inversion.
    logic [ADDR_WIDTH-1:0] r_pc_q   [2];
    logic [31:0]           r_inst_q [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_fetch_ebreak;
    logic                  w_head_ebreak;
    logic [31:0]           w_head_inst;
    logic [ADDR_WIDTH-1:0] w_head_pc;
    logic [ADDR_WIDTH-1:0] w_redirect_aligned;

    assign w_empty = (r_count == 2'd0);
    assign w_full  = (r_count == 2'd2);

    assign w_head_inst = r_inst_q[r_rd_ptr];
    assign w_head_pc   = r_pc_q[r_rd_ptr];

    // A redirect cancels any handshake in its cycle, so valid is masked here.
    assign out_valid = !w_empty && !redirect_valid;
    assign w_pop     = out_valid && out_ready;

    // A full FIFO may still accept a new word when the head leaves this cycle.
    assign w_push = (r_state == S_RUN) && !redirect_valid && (!w_full || w_pop);

    assign w_fetch_ebreak = (rom_data == EBREAK_INST);
    assign w_head_ebreak  = (w_head_inst == EBREAK_INST);

    assign w_redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    assign rom_addr = r_pc;
    assign out_inst = w_empty ? 32'd0 : w_head_inst;
    assign out_pc   = w_empty ? '0    : w_head_pc;
    assign halted   = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_pc_q[i]   <= '0;
                r_inst_q[i] <= 32'd0;
            end
        end else if (redirect_valid) begin
            // Flush: stale entries are dropped by zeroing count and pointers;
            // their storage contents are don't-care once count is zero.
            r_state  <= S_RUN;
            r_pc     <= w_redirect_aligned;
            r_halted <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_pc_q[r_wr_ptr]   <= r_pc;
                r_inst_q[r_wr_ptr] <= rom_data;
                r_wr_ptr           <= ~r_wr_ptr;
                r_pc               <= r_pc + ADDR_WIDTH'(4);
                if (w_fetch_ebreak)
                    r_state <= S_DRAIN;
            end

            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                // Only the ebreak itself ends the drain; older entries ahead
                // of it pop normally.
                if (r_state == S_DRAIN && w_head_ebreak) begin
                    r_state  <= S_HALT;
                    r_halted <= 1'b1;
                end
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020042_ifu.sv
module tb_ysyx_25020042_ifu;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    int errors = 0;
    int checks = 0;

    // ROM model: 16 words at BASE, NOP everywhere else.
    logic [31:0] rom [16];
    logic [31:0] w_off;

    always_comb begin
        w_off    = rom_addr - BASE;
        rom_data = (w_off < 32'd64) ? rom[w_off[5:2]] : NOP;
    end

    ysyx_25020042_ifu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Program with a random body (never an ebreak) and ebreak at index eb.
    // Words after the ebreak are random, so any fetch past it is visible.
    task automatic load_prog(input int eb);
        for (int i = 0; i < 16; i++) begin
            rom[i] = $urandom;
            if (rom[i] == EBREAK) rom[i] = NOP;
        end
        rom[eb] = EBREAK;
    endtask

    // Scoreboard: every accepted handshake must be word idx of the program,
    // in order, at BASE+4*idx, and nothing beyond the ebreak may appear.
    task automatic run_sb(input int start, input int eb, input bit rnd);
        int idx  = start;
        int cyc  = 0;
        bit done = 1'b0;
        while (!done && cyc < 300) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (out_valid && out_ready) begin
                if (idx > eb) begin
                    chk("past_ebreak", 32'(idx), 32'(eb));
                end else begin
                    chk("sb_pc", out_pc, BASE + 32'(4 * idx));
                    chk("sb_inst", out_inst, rom[idx]);
                end
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (halted) done = 1'b1;
        end
        chk("sb_halt_reached", 32'(done), 32'd1);
        chk("sb_delivered", 32'(idx), 32'(eb + 1));
        chk("sb_addr_frozen", rom_addr, BASE + 32'(4 * (eb + 1)));
        out_ready = 1'b1;
        tick();
        tick();
        chk("sb_no_valid_after_halt", 32'(out_valid), 32'd0);
        chk("sb_still_halted", 32'(halted), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        rst_n          = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = NOP;

        // ---------------- basic program, out_ready=1 ----------------
        rom[0] = 32'h0050_0093;
        rom[1] = 32'hffd0_8113;
        rom[2] = EBREAK;
        rst_n  = 1'b0;
        tick();
        chk("rst_rom_addr", rom_addr, BASE);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("b_valid0", 32'(out_valid), 32'd1);
        chk("b_pc0", out_pc, BASE);
        chk("b_inst0", out_inst, 32'h0050_0093);
        tick();
        chk("b_pc1", out_pc, BASE + 32'd4);
        chk("b_inst1", out_inst, 32'hffd0_8113);
        tick();
        chk("b_pc2", out_pc, BASE + 32'd8);
        chk("b_inst2", out_inst, EBREAK);
        chk("b_not_halted_yet", 32'(halted), 32'd0);
        tick();
        chk("b_halted", 32'(halted), 32'd1);
        chk("b_valid_off", 32'(out_valid), 32'd0);
        chk("b_empty_inst", out_inst, 32'd0);
        chk("b_empty_pc", out_pc, 32'd0);
        chk("b_addr_freeze", rom_addr, BASE + 32'd12);
        tick();
        tick();
        chk("b_addr_freeze2", rom_addr, BASE + 32'd12);

        // ---------------- redirect while halted ----------------
        redirect_valid = 1'b1;
        redirect_pc    = BASE;
        #1;
        chk("rh_valid_masked", 32'(out_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        chk("rh_halt_drop", 32'(halted), 32'd0);
        chk("rh_addr", rom_addr, BASE);
        chk("rh_empty", 32'(out_valid), 32'd0);
        tick();
        chk("rh_first_pc", out_pc, BASE);
        chk("rh_first_inst", out_inst, 32'h0050_0093);
        run_sb(0, 2, 1'b0);

        // ---------------- back-pressure ----------------
        load_prog(5);
        out_ready = 1'b0;
        do_reset();
        tick();
        chk("bp_addr1", rom_addr, BASE + 32'd4);
        tick();
        chk("bp_addr2", rom_addr, BASE + 32'd8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_addr_hold", rom_addr, BASE + 32'd8);
            chk("bp_head_hold", out_pc, BASE);
        end
        run_sb(0, 5, 1'b0);

        // ---------------- redirect with 2 queued ----------------
        load_prog(5);
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        chk("rd_full_addr", rom_addr, BASE + 32'd8);
        redirect_valid = 1'b1;
        redirect_pc    = BASE + 32'h12;
        out_ready      = 1'b1;
        #1;
        chk("rd_valid_masked", 32'(out_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        chk("rd_addr_aligned", rom_addr, BASE + 32'h10);
        chk("rd_flushed", 32'(out_valid), 32'd0);
        tick();
        chk("rd_first_pc", out_pc, BASE + 32'h10);
        chk("rd_first_inst", out_inst, rom[4]);
        run_sb(4, 5, 1'b0);

        // ---------------- PC wrap via redirect ----------------
        load_prog(3);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        chk("wr_addr_top", rom_addr, 32'hFFFF_FFFC);
        tick();
        chk("wr_addr_wrap", rom_addr, 32'd0);
        chk("wr_head_pc", out_pc, 32'hFFFF_FFFC);
        chk("wr_head_inst", out_inst, NOP);
        redirect_valid = 1'b1;
        redirect_pc    = BASE;
        tick();
        redirect_valid = 1'b0;
        run_sb(0, 3, 1'b1);

        // ---------------- async reset in DRAIN ----------------
        load_prog(1);
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ar_one_left_pc", out_pc, BASE + 32'd4);
        chk("ar_one_left_inst", out_inst, EBREAK);
        chk("ar_drain_addr", rom_addr, BASE + 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_now", 32'(out_valid), 32'd0);
        chk("ar_halted_now", 32'(halted), 32'd0);
        chk("ar_addr_now", rom_addr, BASE);
        chk("ar_inst_now", out_inst, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_restart_pc", out_pc, BASE);
        chk("ar_restart_addr", rom_addr, BASE + 32'd4);
        run_sb(0, 1, 1'b1);

        // ---------------- random out_ready, random programs ----------------
        for (int r = 0; r < 6; r++) begin
            load_prog(5);
            do_reset();
            run_sb(0, 5, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_25020042_ifu.md
Name: ysyx_25020042_ifu

Overview:
Instruction fetch unit directly upstream of the combinational instruction ROM. It owns the PC, drives the ROM address, and captures the returned word with its PC into a 2-entry prefetch FIFO. The FIFO feeds the decode stage over a valid/ready handshake. The block also handles control-flow redirects and stops fetching after an ebreak (32'h00100073).

Parameters:
ADDR_WIDTH, 32, PC and ROM address width.
RESET_PC, 32'h80000000, first fetch address after reset.
EBREAK_INST, 32'h00100073, encoding that halts fetch.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
rom_addr  output  ADDR_WIDTH  fetch address to the ROM; equals the current PC register.
rom_data  input  32  ROM read data; combinational, valid in the same cycle as rom_addr.
out_valid  output  1  FIFO head is valid for decode.
out_ready  input  1  decode accepts the head this cycle.
out_inst  output  32  instruction at the FIFO head.
out_pc  output  ADDR_WIDTH  PC of the FIFO head.
redirect_valid  input  1  flush and restart fetch at redirect_pc.
redirect_pc  input  ADDR_WIDTH  new fetch target; bits [1:0] are forced to 0.
halted  output  1  ebreak has been handed to decode; fetch is stopped.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, FIFO count=0, state=RUN. Outputs at reset: rom_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0, halted=0.
- FIFO: 2 entries of {pc, inst}, with rd_ptr, wr_ptr and a 2-bit count. Pointers wrap 1->0. out_inst and out_pc show the head entry. Both read 0 when the FIFO is empty.
- out_valid = (count!=0) && !redirect_valid.
- Pop: occurs when out_valid && out_ready.
- Push: occurs when state==RUN && !redirect_valid && (count<2 || pop). The pushed entry is {pc, rom_data}, and pc <= pc+4 in the same cycle. pc wraps modulo 2^ADDR_WIDTH.
- Simultaneous push and pop at count==2 is allowed; count stays at 2. Push and pop at count==0 is not a bypass: the pushed entry is first visible next cycle. Fetch-to-out_valid latency is therefore 1 cycle.
- Ebreak: when a pushed rom_data equals EBREAK_INST, state moves RUN->DRAIN. No further pushes occur, and pc stays at the ebreak PC +4.
- DRAIN->HALT: on the pop of the entry whose inst==EBREAK_INST. halted=1 from the next cycle and stays until reset or redirect.
- Redirect (highest priority, any state): count<=0, pointers<=0, pc<=redirect_pc & ~3, state<=RUN, halted<=0. Any push and pop in that cycle are cancelled; decode must not treat a handshake as accepted while redirect_valid=1. The first new entry is pushed in the cycle after the redirect.
- Entries present in the FIFO ahead of the ebreak still drain normally in DRAIN.
- Reset asserted mid-operation discards all FIFO contents immediately.
- rom_addr changes only on clock edges and never glitches combinationally.

Test Plan:
- Reset then out_ready=1, ROM = {addi 00500093, ffd08113, ebreak}:
  - out_valid rises 1 cycle after reset release.
  - Decode receives pc 80000000/80000004/80000008 with those words on consecutive cycles.
  - halted=1 one cycle after the ebreak pop.
  - rom_addr freezes at 8000000C.
- Back-pressure, out_ready=0 for 5 cycles from reset:
  - count saturates at 2 and rom_addr holds at 80000008.
  - Release out_ready: entries arrive in order with no duplicate and no loss.
- Redirect with 2 entries queued, redirect_pc=80000012, out_ready=1 in the same cycle:
  - out_valid=0 in that cycle.
  - Next cycle rom_addr=80000010 and the FIFO is empty.
  - First delivered out_pc=80000010.
- Redirect while halted, redirect_pc=80000000: halted drops next cycle and fetch restarts from ROM word 0.
- Async reset pulse while in DRAIN with 1 entry queued: out_valid=0 and halted=0 immediately; after release, fetch restarts at 80000000.
- Random out_ready (50%) over a 6-instruction program ending in ebreak: scoreboard confirms in-order delivery, PC = 80000000+4i, and that no entry past the ebreak is delivered.
